// File: rtl/ram_delay_pkg.sv
// Shared constants for the RAM-based delay line: ceiling log2 and the
// address-width derivation used by the interface, the top and the bench.
package ram_delay_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int addr_w(input int max_delay);
    return clog2(max_delay);
  endfunction

endpackage

// File: rtl/ram_delay_line_if.sv
// Sample-stream bundle of the delay line: strobe, input sample and delay
// setting from the producer; delayed sample and its valid flag back.
interface ram_delay_line_if #(
  parameter int N         = 12,
  parameter int MAX_DELAY = 1024
);
  import ram_delay_pkg::*;
  localparam int AW = addr_w(MAX_DELAY);

  logic          ce;
  logic [N-1:0]  idata;
  logic [AW:0]   delay;
  logic [N-1:0]  odata;
  logic          ovalid;

  modport master (output ce, idata, delay, input odata, ovalid);
  modport slave  (input ce, idata, delay, output odata, ovalid);
endinterface

// File: rtl/dp_ram_rf.sv
// Simple dual-port, single-clock, read-first RAM with a strobe-gated
// registered read port; only the read register is reset, never the array.
module dp_ram_rf #(
  parameter int W     = 12,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (ce_i) mem_q[waddr_i] <= wdata_i;
  end

  // Non-blocking read of the same edge returns the old word on an address clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (ce_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ram_delay_line.sv
// Runtime-programmable delay line on a circular buffer with fill tracking.
// Optional RAM_DELAY_LINE_FLUSH_ON_CHANGE_EN: a delay change restarts the fill.
module ram_delay_line #(
  parameter int N         = 12,
  parameter int MAX_DELAY = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_delay_line_if.slave   bus
);
  import ram_delay_pkg::*;
  localparam int AW = addr_w(MAX_DELAY);
  localparam logic [AW:0] MAX_D = (AW+1)'(MAX_DELAY);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   fill_q, fill_d, fill_inc;
  logic [AW:0]   d_clamp;
  logic          ovalid_q, ovalid_d;
  logic          d_zero;
  logic          flush;
  logic [AW-1:0] raddr;
  logic [N-1:0]  rdata;

  always_comb begin
    d_clamp  = (bus.delay > MAX_D) ? MAX_D : bus.delay;
    d_zero   = (d_clamp == '0);
    fill_inc = (fill_q == MAX_D) ? fill_q : fill_q + 1'b1;
    // D = MAX_DELAY truncates to 0 here, so read and write share an address.
    raddr    = wptr_q - d_clamp[AW-1:0];
  end

`ifdef RAM_DELAY_LINE_FLUSH_ON_CHANGE_EN
  logic [AW:0] d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      d_q <= '0;
    else if (bus.ce) d_q <= d_clamp;
  end

  // An empty line has nothing to discard, so the first strobe after reset never flushes.
  assign flush = (d_clamp != d_q) && (fill_q != '0);
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    wptr_d   = wptr_q;
    fill_d   = fill_q;
    ovalid_d = ovalid_q;
    if (bus.ce) begin
      wptr_d = wptr_q + 1'b1;
      if (flush) begin
        fill_d   = '0;
        ovalid_d = 1'b0;
      end else begin
        fill_d   = fill_inc;
        ovalid_d = (fill_inc >= d_clamp);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      fill_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      fill_q   <= fill_d;
      ovalid_q <= ovalid_d;
    end
  end

  dp_ram_rf #(.W(N), .DEPTH(MAX_DELAY), .AW(AW)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce_i    (bus.ce),
    .waddr_i (wptr_q),
    .wdata_i (bus.idata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Zero delay bypasses the RAM entirely, but reset still wins.
  assign bus.odata  = d_zero ? (rst_n ? bus.idata : '0) : rdata;
  assign bus.ovalid = d_zero ? rst_n : ovalid_q;
endmodule

// File: tb/tb_ram_delay_line.sv
// Scoreboard bench for ram_delay_line: stimulus pushes the expected output of
// each strobe, a monitor pops and compares after every strobe edge.
module tb_ram_delay_line;
  import ram_delay_pkg::*;
  localparam int N    = 12;
  localparam int MAXD = 16;
  localparam int AW   = addr_w(MAXD);
`ifdef RAM_DELAY_LINE_FLUSH_ON_CHANGE_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_delay_line_if #(.N(N), .MAX_DELAY(MAXD)) bus ();
  ram_delay_line #(.N(N), .MAX_DELAY(MAXD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic         ov;
    logic         chk;
    logic [N-1:0] data;
  } exp_t;

  exp_t         expq[$];
  exp_t         last_e;
  bit           have_last = 1'b0;
  int           n_pass = 0;
  int           n_total = 0;

  // reference model state
  int           n_edge = 0;
  int           fill = 0;
  int           prev_dc = 0;
  bit           ovq = 1'b0;
  int           cur_delay = 0;
  logic [N-1:0] hist[$];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  function automatic int clampd(input int d);
    return (d > MAXD) ? MAXD : d;
  endfunction

  task automatic strobe(input logic [N-1:0] d);
    exp_t e;
    int   dc;
    @(negedge clk);
    bus.ce    = 1'b1;
    bus.idata = d;
    bus.delay = (AW+1)'(cur_delay);
    dc = clampd(cur_delay);
    n_edge++;
    hist.push_back(d);
    if (FLUSH && dc != prev_dc && fill != 0) begin
      fill = 0;
      ovq  = 1'b0;
    end else begin
      if (fill < MAXD) fill++;
      ovq = (fill >= dc);
    end
    prev_dc = dc;
    e.ov = (dc == 0) ? 1'b1 : ovq;
    if (dc == 0) begin
      e.chk = 1'b1; e.data = d;
    end else if (n_edge > dc) begin
      e.chk = 1'b1; e.data = hist[n_edge-dc-1];
    end else begin
      e.chk = 1'b0; e.data = '0;
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      bus.ce    = 1'b0;
      bus.idata = 12'hABC;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.ce = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_odata", bus.odata, '0);
    check("rst_ovalid", N'(bus.ovalid), '0);
    #1 rst_n = 1'b1;
    n_edge = 0; fill = 0; ovq = 1'b0; prev_dc = 0;
    hist.delete();
    have_last = 1'b0;
  endtask

  // monitor
  always @(posedge clk) begin
    logic fired;
    exp_t e;
    fired = bus.ce && rst_n;
    #1;
    if (fired) begin
      if (expq.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_underflow: got strobe edge expected none at %0t", $time);
      end else begin
        e = expq.pop_front();
        check("ovalid", N'(bus.ovalid), N'(e.ov));
        if (e.chk) check("odata", bus.odata, e.data);
        last_e    = e;
        have_last = 1'b1;
      end
    end else if (rst_n && have_last) begin
      check("hold_ovalid", N'(bus.ovalid), N'(last_e.ov));
      if (last_e.chk) check("hold_odata", bus.odata, last_e.data);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus.ce = 1'b0; bus.idata = '0; bus.delay = '0;
    #3;
    check("init_odata", bus.odata, '0);
    check("init_ovalid", N'(bus.ovalid), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // D=3, continuous strobes, then hold
    cur_delay = 3;
    for (int i = 1; i <= 12; i++) strobe(N'(i));
    idle(3);

    // D=16, wrap with read-first
    do_reset();
    cur_delay = 16;
    for (int i = 0; i < 40; i++) strobe(N'(100 + i));
    idle(2);

    // D=4, one strobe in three
    do_reset();
    cur_delay = 4;
    for (int i = 0; i < 15; i++) begin
      strobe(N'(12'h300 + i));
      idle(2);
    end

    // D=20 clamps to 16, then D=0 bypass
    do_reset();
    cur_delay = 20;
    for (int i = 0; i < 20; i++) strobe(N'(12'h500 + i));
    cur_delay = 0;
    for (int i = 0; i < 5; i++) strobe(N'(12'h7F0 + i));

    // D=1
    do_reset();
    cur_delay = 1;
    for (int i = 0; i < 5; i++) strobe(N'(12'h900 + i));

    // D change 3 -> 5 after 10 samples
    do_reset();
    cur_delay = 3;
    for (int i = 0; i < 10; i++) strobe(N'(12'hA00 + i));
    cur_delay = 5;
    for (int i = 10; i < 22; i++) strobe(N'(12'hA00 + i));

    // reset mid-stream, refill at D=5
    do_reset();
    for (int i = 0; i < 9; i++) strobe(N'(12'hC00 + i));
    idle(3);

    if (expq.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
